// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: 640x480@60 constants, total-size helpers
// and the raster bundle handed to downstream compositors.
package video_timing_pkg;

  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_VIS  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;

  localparam int VGA_V_VIS  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Pixels per line including blanking.
  function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Lines per frame including blanking.
  function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Raster position and decodes as seen by a compositor.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        h_sync;
    logic        v_sync;
    logic        active;
  } raster_t;

endpackage

// File: rtl/pixel_ce_divider.sv
// Pixel clock-enable divider: one tick every CLK_DIV enabled system clocks.
// The tick is flagged combinationally in the cycle the count sits at
// CLK_DIV-1 so the consumer can load new values on that same edge.
module pixel_ce_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] count_reg;

  assign o_tick = i_enable && (count_reg == LAST);

  // Phase counter; freezes while disabled so resuming keeps the old phase.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_reg <= '0;
    end else if (i_enable) begin
      count_reg <= o_tick ? 8'd0 : count_reg + 8'd1;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Raster scan generator: x/y counters, sync/active decodes and frame
// bookkeeping, advancing one pixel per divider tick. All outputs registered.
module vga_timing_generator
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV         = VGA_CLK_DIV,
  parameter int H_VIS           = VGA_H_VIS,
  parameter int H_FP            = VGA_H_FP,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BP            = VGA_H_BP,
  parameter int V_VIS           = VGA_V_VIS,
  parameter int V_FP            = VGA_V_FP,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BP            = VGA_V_BP,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_active,
  output logic        o_pixel_ce,
  output logic        o_frame_start,
  output logic [15:0] o_frame_count
);

  localparam int H_TOTAL = h_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_FIRST = 16'(H_VIS + H_FP);
  localparam logic [15:0] HS_LAST  = 16'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST = 16'(V_VIS + V_FP);
  localparam logic [15:0] VS_LAST  = 16'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [15:0] H_VIS_W  = 16'(H_VIS);
  localparam logic [15:0] V_VIS_W  = 16'(V_VIS);

  // Asserted sync level; the idle level is its complement.
  localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("vga_timing_generator: CLK_DIV must be in 1..255");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_generator: every porch and sync width must be at least 1");
  end

  logic        tick;
  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        frame_wrap;
  raster_t     raster_next;
  raster_t     raster_reg;
  logic        pixel_ce_reg;
  logic        frame_start_reg;
  logic [15:0] frame_count_reg;

  pixel_ce_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_ce_divider (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  // Position the raster moves to on the next tick, with line/frame wrap.
  always_comb begin
    x_next     = raster_reg.x + 16'd1;
    y_next     = raster_reg.y;
    frame_wrap = 1'b0;
    if (raster_reg.x == H_LAST) begin
      x_next = '0;
      if (raster_reg.y == V_LAST) begin
        y_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        y_next = raster_reg.y + 16'd1;
      end
    end
  end

  // Decodes taken from the next position so they register alongside x/y.
  always_comb begin
    raster_next.x      = x_next;
    raster_next.y      = y_next;
    raster_next.h_sync = (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
    raster_next.v_sync = (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    raster_next.active = (x_next < H_VIS_W) && (y_next < V_VIS_W);
  end

  // Output registers; reset parks the raster on the last pixel of a frame so
  // the first tick lands on (0,0) as a frame start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      raster_reg.x      <= H_LAST;
      raster_reg.y      <= V_LAST;
      raster_reg.h_sync <= ~SYNC_ON;
      raster_reg.v_sync <= ~SYNC_ON;
      raster_reg.active <= 1'b0;
      pixel_ce_reg      <= 1'b0;
      frame_start_reg   <= 1'b0;
      frame_count_reg   <= '0;
    end else begin
      pixel_ce_reg    <= tick;
      frame_start_reg <= tick && frame_wrap;
      if (tick) begin
        raster_reg <= raster_next;
        if (frame_wrap) begin
          frame_count_reg <= frame_count_reg + 16'd1;
        end
      end
    end
  end

  assign o_x           = raster_reg.x;
  assign o_y           = raster_reg.y;
  assign o_h_sync      = raster_reg.h_sync;
  assign o_v_sync      = raster_reg.v_sync;
  assign o_active      = raster_reg.active;
  assign o_pixel_ce    = pixel_ce_reg;
  assign o_frame_start = frame_start_reg;
  assign o_frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench: a reference raster model pushes expected pixels to a
// scoreboard on each predicted tick; each scenario pops and compares when the
// DUT raises o_pixel_ce. Instance A: CLK_DIV=4, 800-pixel lines, 8-line frame.
// Instance B: CLK_DIV=1, 7x5 raster.
`timescale 1ns/1ps
module tb_vga_timing_generator;

  localparam int A_DIV = 4;
  localparam int A_HT  = 800;
  localparam int A_VT  = 8;
  localparam int A_FRAME_CLKS = A_HT * A_VT * A_DIV;
  localparam int B_HT  = 7;
  localparam int B_VT  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, hs_a, vs_a, act_a, ce_a, fs_a;
  logic [15:0] x_a, y_a, fc_a;
  logic        rst_b, en_b, hs_b, vs_b, act_b, ce_b, fs_b;
  logic [15:0] x_b, y_b, fc_b;

  vga_timing_generator #(
    .CLK_DIV(4), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_enable(en_a),
    .o_x(x_a), .o_y(y_a), .o_h_sync(hs_a), .o_v_sync(vs_a), .o_active(act_a),
    .o_pixel_ce(ce_a), .o_frame_start(fs_a), .o_frame_count(fc_a)
  );

  vga_timing_generator #(
    .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_LOW(1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_enable(en_b),
    .o_x(x_b), .o_y(y_b), .o_h_sync(hs_b), .o_v_sync(vs_b), .o_active(act_b),
    .o_pixel_ce(ce_b), .o_frame_start(fs_b), .o_frame_count(fc_b)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for instance A.
  int m_div, m_x, m_y, m_fc;

  // Expected pixel for A: hsync low on 656..751, vsync low on lines 5..6.
  function automatic exp_t expect_a(input int x, input int y, input int fc, input bit fs);
    exp_t e;
    e.x   = 16'(x);
    e.y   = 16'(y);
    e.hs  = !(x >= 656 && x <= 751);
    e.vs  = !(y >= 5 && y <= 6);
    e.act = (x < 640) && (y < 4);
    e.fs  = fs;
    e.fc  = 16'(fc);
    return e;
  endfunction

  // Expected pixel for B: hsync low at x=5, vsync low on line 3.
  function automatic exp_t expect_b(input int x, input int y, input int fc, input bit fs);
    exp_t e;
    e.x   = 16'(x);
    e.y   = 16'(y);
    e.hs  = (x != 5);
    e.vs  = (y != 3);
    e.act = (x < 4) && (y < 2);
    e.fs  = fs;
    e.fc  = 16'(fc);
    return e;
  endfunction

  task automatic model_a_reset();
    m_div = 0;
    m_x   = A_HT - 1;
    m_y   = A_VT - 1;
    m_fc  = 0;
    sb_a.delete();
  endtask

  // Advance the model by one clock edge; a predicted tick pushes the pixel.
  task automatic model_a_step();
    bit fs;
    fs = 1'b0;
    if (rst_a || !en_a) return;
    if (m_div == A_DIV - 1) begin
      m_div = 0;
      if (m_x == A_HT - 1) begin
        m_x = 0;
        if (m_y == A_VT - 1) begin
          m_y  = 0;
          fs   = 1'b1;
          m_fc = (m_fc + 1) % 65536;
        end else begin
          m_y = m_y + 1;
        end
      end else begin
        m_x = m_x + 1;
      end
      sb_a.push_back(expect_a(m_x, m_y, m_fc, fs));
    end else begin
      m_div = m_div + 1;
    end
  endtask

  // One clock of A: edge, model update, then settle before sampling.
  task automatic clock_a();
    @(posedge clk);
    model_a_step();
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    model_a_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x_a, y_a, hs_a, vs_a, act_a, ce_a, fs_a, fc_a} !== {16'd799, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state_a: got x=%0d y=%0d hs=%b vs=%b act=%b ce=%b fs=%b fc=%0d, expected 799 7 1 1 0 0 0 0",
               x_a, y_a, hs_a, vs_a, act_a, ce_a, fs_a, fc_a);
    end
    checks++;
    if ({x_b, y_b, ce_b, fc_b} !== {16'd6, 16'd4, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state_b: got x=%0d y=%0d ce=%b fc=%0d, expected 6 4 0 0", x_b, y_b, ce_b, fc_b);
    end
    rst_a = 1'b0; en_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      clock_a();
      checks++;
      if (ce_a !== 1'b0 || x_a !== 16'd799 || fc_a !== 16'd0) begin
        errors++;
        $display("FAIL release_hold clk%0d: got ce=%b x=%0d fc=%0d, expected 0 799 0", i, ce_a, x_a, fc_a);
      end
    end
    clock_a();
    checks++;
    if (ce_a !== 1'b1 || sb_a.size() == 0) begin
      errors++;
      $display("FAIL first_tick: got ce=%b queued=%0d, expected ce=1 queued=1", ce_a, sb_a.size());
      sb_a.delete();
    end else begin
      e   = sb_a.pop_front();
      got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
      checks++;
      if (got !== e || e.fs !== 1'b1 || e.fc !== 16'd1) begin
        errors++;
        $display("FAIL first_pixel: got %h, expected %h (x=0 y=0 act=1 fs=1 fc=1)", got, e);
      end
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  // One full frame of A checked pixel by pixel, plus sync widths and wraps.
  task automatic test_full_frame();
    exp_t e, got;
    int last_ce, hs_cnt, vs_cnt, fs_cnt, prev_x, prev_y;
    last_ce = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    prev_x = 0; prev_y = 0;
    for (int cyc = 1; cyc <= A_FRAME_CLKS; cyc++) begin
      clock_a();
      if (ce_a === 1'b1) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ce at cycle %0d: got ce=1 x=%0d y=%0d, expected ce=0", cyc, x_a, y_a);
        end else begin
          e   = sb_a.pop_front();
          got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
          if (got !== e) begin
            errors++;
            $display("FAIL pixel at cycle %0d: got %h, expected %h", cyc, got, e);
          end
        end
        checks++;
        if (cyc - last_ce != A_DIV) begin
          errors++;
          $display("FAIL ce_spacing at cycle %0d: got %0d clocks, expected %0d", cyc, cyc - last_ce, A_DIV);
        end
        if (x_a == 16'd0) begin
          checks++;
          if (prev_x != A_HT - 1 || int'(y_a) != (prev_y + 1) % A_VT) begin
            errors++;
            $display("FAIL line_wrap: got (%0d,%0d)->(0,%0d), expected (799,y)->(0,y+1 mod 8)", prev_x, prev_y, y_a);
          end
        end
        if (x_a == 16'd640) begin
          checks++;
          if (act_a !== 1'b0) begin
            errors++;
            $display("FAIL active_x640: got act=%b, expected 0", act_a);
          end
        end
        last_ce = cyc;
        prev_x  = int'(x_a);
        prev_y  = int'(y_a);
        if (hs_a === 1'b0) hs_cnt++;
        if (vs_a === 1'b0) vs_cnt++;
        if (fs_a === 1'b1) fs_cnt++;
      end else begin
        checks++;
        if (sb_a.size() != 0 || fs_a !== 1'b0) begin
          errors++;
          $display("FAIL missing_ce at cycle %0d: got ce=%b fs=%b, expected ce=%0d fs=0", cyc, ce_a, fs_a, sb_a.size());
          sb_a.delete();
        end
      end
    end
    checks++;
    if (hs_cnt != 96 * A_VT) begin
      errors++;
      $display("FAIL hsync_width: got %0d pixels, expected %0d", hs_cnt, 96 * A_VT);
    end
    checks++;
    if (vs_cnt != 1600) begin
      errors++;
      $display("FAIL vsync_width: got %0d pixels, expected 1600", vs_cnt);
    end
    checks++;
    if (fs_cnt != 1 || fs_a !== 1'b1 || x_a !== 16'd0 || y_a !== 16'd0 || fc_a !== 16'd2) begin
      errors++;
      $display("FAIL frame_wrap: got starts=%0d fs=%b at (%0d,%0d) fc=%0d, expected 1 1 (0,0) 2",
               fs_cnt, fs_a, x_a, y_a, fc_a);
    end
    clock_a();
    checks++;
    if (fs_a !== 1'b0 || ce_a !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_width: got fs=%b ce=%b one clock later, expected 0 0", fs_a, ce_a);
    end
    $display("test_full_frame done: errors=%0d", errors);
  endtask

  // Freeze mid-phase at x=100, then check the remaining phase on resume.
  task automatic test_enable_freeze();
    exp_t e, got;
    logic [50:0] snap;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      clock_a();
      if (ce_a === 1'b1) begin
        if (sb_a.size() != 0) begin
          e   = sb_a.pop_front();
          got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL pixel_before_freeze: got %h, expected %h", got, e);
          end
        end
        if (x_a == 16'd100) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_x100: got no ce at x=100 within 1000 clocks, expected one");
    end
    clock_a();
    clock_a();
    snap = {x_a, y_a, hs_a, vs_a, act_a, fc_a};
    en_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      clock_a();
      checks++;
      if (ce_a !== 1'b0 || fs_a !== 1'b0 || {x_a, y_a, hs_a, vs_a, act_a, fc_a} !== snap) begin
        errors++;
        $display("FAIL frozen clk%0d: got ce=%b fs=%b state=%h, expected 0 0 %h", i, ce_a, fs_a,
                 {x_a, y_a, hs_a, vs_a, act_a, fc_a}, snap);
      end
    end
    en_a = 1'b1;
    clock_a();
    checks++;
    if (ce_a !== 1'b0) begin
      errors++;
      $display("FAIL resume_phase: got ce=%b one clock after resume, expected 0", ce_a);
    end
    clock_a();
    checks++;
    if (ce_a !== 1'b1 || x_a !== 16'd101 || sb_a.size() == 0) begin
      errors++;
      $display("FAIL resume_tick: got ce=%b x=%0d, expected ce=1 x=101", ce_a, x_a);
      sb_a.delete();
    end else begin
      e   = sb_a.pop_front();
      got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL resume_pixel: got %h, expected %h", got, e);
      end
    end
    $display("test_enable_freeze done: errors=%0d", errors);
  endtask

  // Reset between edges at (300,1): outputs must clear with no clock.
  task automatic test_async_reset();
    exp_t e, got;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      clock_a();
      if (ce_a === 1'b1) begin
        if (sb_a.size() != 0) begin
          e   = sb_a.pop_front();
          got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL pixel_before_reset: got %h, expected %h", got, e);
          end
        end
        if (x_a == 16'd300 && y_a == 16'd1) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_300_1: got no ce at (300,1) within 10000 clocks, expected one");
    end
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({x_a, y_a, hs_a, vs_a, act_a, ce_a, fs_a} !== {16'd799, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_state: got x=%0d y=%0d hs=%b vs=%b act=%b ce=%b fs=%b, expected 799 7 1 1 0 0 0",
               x_a, y_a, hs_a, vs_a, act_a, ce_a, fs_a);
    end
    checks++;
    if (fc_a !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_count: got fc=%0d, expected 0", fc_a);
    end
    model_a_reset();
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      clock_a();
      checks++;
      if (ce_a !== (i == 4)) begin
        errors++;
        $display("FAIL restart_ce clk%0d: got ce=%b, expected %b", i, ce_a, (i == 4));
      end
    end
    checks++;
    if (sb_a.size() == 0) begin
      errors++;
      $display("FAIL restart_pixel: got no predicted pixel, expected one");
    end else begin
      e   = sb_a.pop_front();
      got = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, act: act_a, fs: fs_a, fc: fc_a};
      if (got !== e || fs_a !== 1'b1 || fc_a !== 16'd1) begin
        errors++;
        $display("FAIL restart_pixel: got %h, expected %h (fs=1 fc=1)", got, e);
      end
    end
    $display("test_async_reset done: errors=%0d", errors);
  endtask

  // CLK_DIV=1 on a 7x5 raster: ce every clock and 35-clock frames.
  task automatic test_small_raster();
    exp_t e, got;
    int p;
    en_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int k = 1; k <= 200 * B_HT * B_VT; k++) begin
      p = (k - 1) % (B_HT * B_VT);
      sb_b.push_back(expect_b(p % B_HT, p / B_HT, ((k - 1) / (B_HT * B_VT) + 1) % 65536, p == 0));
      @(posedge clk);
      #1;
      checks++;
      e   = sb_b.pop_front();
      got = '{x: x_b, y: y_b, hs: hs_b, vs: vs_b, act: act_b, fs: fs_b, fc: fc_b};
      if (ce_b !== 1'b1 || got !== e) begin
        errors++;
        $display("FAIL small_pixel clk%0d: got ce=%b %h, expected ce=1 %h", k, ce_b, got, e);
      end
    end
    checks++;
    if (fc_b !== 16'd200) begin
      errors++;
      $display("FAIL small_frame_count: got %0d, expected 200", fc_b);
    end
    $display("test_small_raster done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_enable_freeze();
    test_async_reset();
    test_small_raster();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running at 5 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
